// File: rtl/mips_regfile_operand_stage.sv
// MIPS register file feeding the ID/EX operand register (a, b, OpALU, funct, valid).
// Define REGFILE_BYPASS_EN to forward a same-cycle write-back into the operand capture.
module mips_regfile_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [0:ADDR_W-1] rs_addr,
  input  logic [0:ADDR_W-1] rt_addr,
  input  logic [0:1]        op_alu_in,
  input  logic [0:5]        funct_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [0:ADDR_W-1] wr_addr,
  input  logic [0:DATA_W-1] wr_data,
  output logic [0:DATA_W-1] a,
  output logic [0:DATA_W-1] b,
  output logic [0:1]        OpALU,
  output logic [0:5]        funct,
  output logic              out_valid
);

  localparam int NumRegs = 2 ** ADDR_W;

  logic [0:DATA_W-1] regFile [NumRegs];
  logic [0:DATA_W-1] rdA;
  logic [0:DATA_W-1] rdB;
  logic              wrActive;

  assign wrActive = wr_en && (wr_addr != '0);

  // Register 0 is never written, so the read path forces it to zero.
  function automatic logic [0:DATA_W-1] readReg(input logic [0:ADDR_W-1] addr);
    logic [0:DATA_W-1] value;
    value = regFile[addr];
    if (addr == '0) begin
      value = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (wrActive && (wr_addr == addr)) begin
      value = wr_data;
    end
`endif
    return value;
  endfunction

  always_comb begin
    rdA = readReg(rs_addr);
    rdB = readReg(rt_addr);
  end

  // Write-back ignores stall/flush; only reset suppresses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regFile[i] <= '0;
      end
    end else if (wrActive) begin
      regFile[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      a         <= '0;
      b         <= '0;
      OpALU     <= '0;
      funct     <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      a         <= rdA;
      b         <= rdB;
      OpALU     <= op_alu_in;
      funct     <= funct_in;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_mips_regfile_operand_stage.sv
// Bench for mips_regfile_operand_stage: directed cases then random traffic against an array model.
module tb_mips_regfile_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [0:4]  rs_addr;
  logic [0:4]  rt_addr;
  logic [0:1]  op_alu_in;
  logic [0:5]  funct_in;
  logic        stall;
  logic        flush;
  logic        wr_en;
  logic [0:4]  wr_addr;
  logic [0:31] wr_data;
  logic [0:31] a;
  logic [0:31] b;
  logic [0:1]  OpALU;
  logic [0:5]  funct;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [32];
  logic [31:0] expA, expB;
  logic [1:0]  expOp;
  logic [5:0]  expFn;
  logic        expV;

  always #5 clk = ~clk;

  mips_regfile_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .op_alu_in(op_alu_in), .funct_in(funct_in), .stall(stall), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .a(a), .b(b),
    .OpALU(OpALU), .funct(funct), .out_valid(out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input int addr);
    if (addr == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (int'(wr_addr) == addr)) return wr_data;
`endif
    return model[addr];
  endfunction

  // One clock: apply inputs, advance the model, compare all outputs.
  task automatic step(input logic r, input logic iv, input int rs, input int rt,
                      input logic [1:0] op, input logic [5:0] fn, input logic st,
                      input logic fl, input logic we, input int wa, input logic [31:0] wd);
    rst = r; in_valid = iv; rs_addr = 5'(rs); rt_addr = 5'(rt); op_alu_in = op;
    funct_in = fn; stall = st; flush = fl; wr_en = we; wr_addr = 5'(wa); wr_data = wd;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      expA = 0; expB = 0; expOp = 0; expFn = 0; expV = 0;
    end else begin
      if (fl) begin
        expA = 0; expB = 0; expOp = 0; expFn = 0; expV = 0;
      end else if (!st) begin
        expA = modelRead(rs); expB = modelRead(rt); expOp = op; expFn = fn; expV = iv;
      end
      if (we && wa != 0) model[wa] = wd;
    end
    #1;
    chk("a", a, expA);
    chk("b", b, expB);
    chk("OpALU", 32'(OpALU), 32'(expOp));
    chk("funct", 32'(funct), 32'(expFn));
    chk("out_valid", 32'(out_valid), 32'(expV));
    $display("t=%0t rst=%0d fl=%0d st=%0d rs=%0d rt=%0d we=%0d wa=%0d a=%h b=%h v=%0d",
             $time, r, fl, st, rs, rt, we, wa, a, b, out_valid);
  endtask

  initial begin
    @(negedge clk);
    // Reset for two cycles with a write-back pending: it must be discarded.
    step(1, 1, 3, 3, 2'b11, 6'h3f, 0, 0, 1, 3, 32'hDEAD_BEEF);
    step(1, 1, 3, 3, 2'b11, 6'h3f, 0, 0, 1, 3, 32'hDEAD_BEEF);
    chk("rst_a", a, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    step(0, 1, 3, 3, 2'b00, 6'h00, 0, 0, 0, 0, 32'h0);
    chk("after_rst_r3", a, 32'h0);

    // Write r5, then load it.
    step(0, 0, 0, 0, 2'b00, 6'h00, 0, 0, 1, 5, 32'h0000_00A5);
    step(0, 1, 5, 0, 2'b10, 6'b100000, 0, 0, 0, 0, 32'h0);
    chk("load_r5_a", a, 32'hA5);
    chk("load_r5_op", 32'(OpALU), 32'h2);
    chk("load_r5_fn", 32'(funct), 32'h20);

    // r0 write ignored.
    step(0, 0, 0, 0, 2'b00, 6'h00, 0, 0, 1, 0, 32'hFFFF_FFFF);
    step(0, 1, 0, 0, 2'b01, 6'h01, 0, 0, 0, 0, 32'h0);
    chk("r0_zero", a, 32'h0);

    // Same-cycle write/read collision on r7.
    step(0, 1, 7, 7, 2'b00, 6'h02, 0, 0, 1, 7, 32'h0000_1234);
`ifdef REGFILE_BYPASS_EN
    chk("collide_r7", a, 32'h1234);
`else
    chk("collide_r7", a, 32'h0);
`endif
    step(0, 1, 7, 0, 2'b00, 6'h02, 0, 0, 0, 0, 32'h0);
    chk("r7_next", a, 32'h1234);

    // Stall holds across changing addresses, then flush wins over stall.
    step(0, 1, 5, 5, 2'b10, 6'h22, 0, 0, 0, 0, 32'h0);
    step(0, 1, 7, 1, 2'b01, 6'h01, 1, 0, 0, 0, 32'h0);
    step(0, 0, 2, 3, 2'b00, 6'h05, 1, 0, 0, 0, 32'h0);
    step(0, 1, 9, 4, 2'b11, 6'h07, 1, 0, 0, 0, 32'h0);
    chk("stall_hold", a, 32'hA5);
    step(0, 1, 5, 5, 2'b10, 6'h22, 1, 1, 0, 0, 32'h0);
    chk("flush_a", a, 32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);

    // Flush does not block write-back.
    step(0, 1, 5, 5, 2'b10, 6'h22, 0, 1, 1, 9, 32'h55);
    step(0, 1, 9, 9, 2'b10, 6'h22, 0, 0, 0, 0, 32'h0);
    chk("flush_wb_r9", a, 32'h55);

    // Random traffic; small address range to force collisions.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom), $urandom_range(0, 7),
           $urandom_range(0, 7), 2'($urandom), 6'($urandom),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom), $urandom_range(0, 7), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
